// File: rtl/llc_mem_responder_pkg.sv
// Shared constants, types and responder FSM states for the LLC memory responder.
package llc_mem_responder_pkg;

  localparam int unsigned LLC_LINE_BITS      = 128;
  localparam int unsigned LLC_LINE_ADDR_BITS = 28;

  typedef logic [LLC_LINE_BITS-1:0]      line_t;
  typedef logic [LLC_LINE_ADDR_BITS-1:0] line_addr_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } rsp_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/llc_mem_responder_if.sv
// LLC memory request/response channel; master = LLC side, slave = memory side.
interface llc_mem_responder_if
  import llc_mem_responder_pkg::*;
#(
  parameter int unsigned LINE_BITS      = LLC_LINE_BITS,
  parameter int unsigned LINE_ADDR_BITS = LLC_LINE_ADDR_BITS
);

  logic                      llc_mem_req_valid;
  logic                      llc_mem_req_ready;
  logic                      llc_mem_req_hwrite;
  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr;
  logic [2:0]                llc_mem_req_hsize;
  logic [1:0]                llc_mem_req_hprot;
  logic [LINE_BITS-1:0]      llc_mem_req_line;
  logic                      llc_mem_rsp_valid;
  logic                      llc_mem_rsp_ready;
  logic [LINE_BITS-1:0]      llc_mem_rsp_line;

  modport master (
    output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_addr,
           llc_mem_req_hsize, llc_mem_req_hprot, llc_mem_req_line,
           llc_mem_rsp_ready,
    input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
  );

  modport slave (
    input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_addr,
           llc_mem_req_hsize, llc_mem_req_hprot, llc_mem_req_line,
           llc_mem_rsp_ready,
    output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
  );

endinterface

// File: rtl/llc_mem_responder_ram.sv
// Single-port line-wide synchronous RAM: registered read, write-first, no array reset.
module llc_mem_responder_ram #(
  parameter int unsigned WIDTH    = 128,
  parameter int unsigned IDX_BITS = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [IDX_BITS-1:0] addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem [2**IDX_BITS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/llc_mem_responder.sv
// Memory-side responder: clears its backing store after reset, then serves
// line reads/writes with a fixed read latency and one outstanding read.
module llc_mem_responder
  import llc_mem_responder_pkg::*;
#(
  parameter int unsigned LINE_BITS      = LLC_LINE_BITS,
  parameter int unsigned LINE_ADDR_BITS = LLC_LINE_ADDR_BITS,
  parameter int unsigned MEM_IDX_BITS   = 10,
  parameter int unsigned RD_LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  llc_mem_responder_if.slave   bus,
  output logic                 init_done,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  rsp_state_t state, state_nxt;

  logic [MEM_IDX_BITS-1:0]   init_idx;
  logic [3:0]                lat_cnt;
  logic                      rsp_valid_q;
  logic [LINE_BITS-1:0]      rsp_line_q;
  logic [LINE_ADDR_BITS-1:0] req_addr;
  logic                      req_fire, rd_fire, wr_fire, rsp_fire;

  logic                      ram_en, ram_we;
  logic [MEM_IDX_BITS-1:0]   ram_addr;
  logic [LINE_BITS-1:0]      ram_wdata, ram_rdata;

  // Upper address bits alias; size/protection are carried but unused.
  logic unused_ok;
  assign unused_ok = ^{bus.llc_mem_req_hsize, bus.llc_mem_req_hprot, req_addr};

  assign req_addr = bus.llc_mem_req_addr;
  assign req_fire = (state == IDLE) && bus.llc_mem_req_valid;
  assign rd_fire  = req_fire && !bus.llc_mem_req_hwrite;
  assign wr_fire  = req_fire && bus.llc_mem_req_hwrite;
  assign rsp_fire = rsp_valid_q && bus.llc_mem_rsp_ready;

  assign bus.llc_mem_rsp_valid = rsp_valid_q;
  assign bus.llc_mem_rsp_line  = rsp_line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT: if (init_idx == '1) state_nxt = IDLE;
      IDLE: if (rd_fire) state_nxt = (RD_LATENCY == 1) ? RESP : WAIT;
      WAIT: if (lat_cnt == 4'd1) state_nxt = RESP;
      RESP: if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // The INIT clearing port is muxed in front of the request port.
  always_comb begin
    bus.llc_mem_req_ready = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = init_idx;
    ram_wdata = '0;
    unique case (state)
      INIT: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      IDLE: begin
        bus.llc_mem_req_ready = 1'b1;
        ram_en    = bus.llc_mem_req_valid;
        ram_we    = bus.llc_mem_req_hwrite;
        ram_addr  = req_addr[MEM_IDX_BITS-1:0];
        ram_wdata = bus.llc_mem_req_line;
      end
      default: ;
    endcase
  end

  // Entering RESP takes one more edge to present the line, so WAIT ends at
  // lat_cnt==1 and valid still lands RD_LATENCY edges after the accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_idx    <= '0;
      init_done   <= 1'b0;
      lat_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_line_q  <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      if (state == INIT) init_idx <= init_idx + MEM_IDX_BITS'(1);
      if (state == INIT && init_idx == '1) init_done <= 1'b1;

      if (rd_fire)            lat_cnt <= 4'(RD_LATENCY - 1);
      else if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;

      if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
      end else if (state == RESP && !rsp_valid_q) begin
        rsp_valid_q <= 1'b1;
        rsp_line_q  <= ram_rdata;
      end

      if (rd_fire) rd_count <= sat_inc16(rd_count);
      if (wr_fire) wr_count <= sat_inc16(wr_count);
    end
  end

  llc_mem_responder_ram #(
    .WIDTH    (LINE_BITS),
    .IDX_BITS (MEM_IDX_BITS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_llc_mem_responder.sv
// Bench for llc_mem_responder: two builds (RD_LATENCY 4 and 1, 16-line store)
// checked every cycle against a transaction-level model plus directed literals.
module tb_llc_mem_responder;
  import llc_mem_responder_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_hwrite, rsp_ready;
  logic [1:0]  req_ready, rsp_valid, init_done;
  line_addr_t  req_addr  [2];
  logic [2:0]  req_hsize [2];
  logic [1:0]  req_hprot [2];
  line_t       req_line  [2];
  line_t       rsp_line  [2];
  logic [15:0] rd_count  [2];
  logic [15:0] wr_count  [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  llc_mem_responder_if #(.LINE_BITS(LLC_LINE_BITS), .LINE_ADDR_BITS(LLC_LINE_ADDR_BITS)) bus0 ();
  llc_mem_responder_if #(.LINE_BITS(LLC_LINE_BITS), .LINE_ADDR_BITS(LLC_LINE_ADDR_BITS)) bus1 ();

  assign bus0.llc_mem_req_valid  = req_valid[0];
  assign bus0.llc_mem_req_hwrite = req_hwrite[0];
  assign bus0.llc_mem_req_addr   = req_addr[0];
  assign bus0.llc_mem_req_hsize  = req_hsize[0];
  assign bus0.llc_mem_req_hprot  = req_hprot[0];
  assign bus0.llc_mem_req_line   = req_line[0];
  assign bus0.llc_mem_rsp_ready  = rsp_ready[0];
  assign req_ready[0] = bus0.llc_mem_req_ready;
  assign rsp_valid[0] = bus0.llc_mem_rsp_valid;
  assign rsp_line[0]  = bus0.llc_mem_rsp_line;

  assign bus1.llc_mem_req_valid  = req_valid[1];
  assign bus1.llc_mem_req_hwrite = req_hwrite[1];
  assign bus1.llc_mem_req_addr   = req_addr[1];
  assign bus1.llc_mem_req_hsize  = req_hsize[1];
  assign bus1.llc_mem_req_hprot  = req_hprot[1];
  assign bus1.llc_mem_req_line   = req_line[1];
  assign bus1.llc_mem_rsp_ready  = rsp_ready[1];
  assign req_ready[1] = bus1.llc_mem_req_ready;
  assign rsp_valid[1] = bus1.llc_mem_rsp_valid;
  assign rsp_line[1]  = bus1.llc_mem_rsp_line;

  llc_mem_responder #(
    .LINE_BITS(LLC_LINE_BITS), .LINE_ADDR_BITS(LLC_LINE_ADDR_BITS),
    .MEM_IDX_BITS(4), .RD_LATENCY(4)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .init_done(init_done[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0])
  );

  llc_mem_responder #(
    .LINE_BITS(LLC_LINE_BITS), .LINE_ADDR_BITS(LLC_LINE_ADDR_BITS),
    .MEM_IDX_BITS(4), .RD_LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .init_done(init_done[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1])
  );

  // Transaction-level model: store contents, one pending read with its age in
  // edges since accept, and accepted-request tallies.
  line_t       m_mem  [2][DEPTH];
  int unsigned m_init [2];
  logic        m_pend [2];
  int unsigned m_age  [2];
  line_t       m_data [2];
  int unsigned m_rd   [2];
  int unsigned m_wr   [2];

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 32'd4 : 32'd1;
  endfunction

  function automatic logic exp_ready(input int d);
    return (m_init[d] == DEPTH) && !m_pend[d];
  endfunction

  function automatic logic exp_valid(input int d);
    return m_pend[d] && (m_age[d] >= lat_of(d));
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_init[d] <= 0;
        m_pend[d] <= 1'b0;
        m_age[d]  <= 0;
        m_rd[d]   <= 0;
        m_wr[d]   <= 0;
        for (int i = 0; i < DEPTH; i++) m_mem[d][i] <= '0;
      end else if (m_init[d] < DEPTH) begin
        m_init[d] <= m_init[d] + 1;
      end else if (!m_pend[d]) begin
        if (req_valid[d]) begin
          if (req_hwrite[d]) begin
            m_mem[d][req_addr[d][3:0]] <= req_line[d];
            if (m_wr[d] < 65535) m_wr[d] <= m_wr[d] + 1;
          end else begin
            m_pend[d] <= 1'b1;
            m_age[d]  <= 0;
            m_data[d] <= m_mem[d][req_addr[d][3:0]];
            if (m_rd[d] < 65535) m_rd[d] <= m_rd[d] + 1;
          end
        end
      end else if (m_age[d] >= lat_of(d)) begin
        if (rsp_ready[d]) m_pend[d] <= 1'b0;
      end else begin
        m_age[d] <= m_age[d] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h required %h", nm, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready", d, 128'(req_ready[d]), 128'(exp_ready(d)));
        chk("rsp_valid", d, 128'(rsp_valid[d]), 128'(exp_valid(d)));
        if (exp_valid(d)) chk("rsp_line", d, rsp_line[d], m_data[d]);
        chk("init_done", d, 128'(init_done[d]), 128'(m_init[d] == DEPTH));
        chk("rd_count", d, 128'(rd_count[d]), 128'(m_rd[d]));
        chk("wr_count", d, 128'(wr_count[d]), 128'(m_wr[d]));
      end
    end
  end

  // Called and returns at #1 after a posedge; returns just after the accept edge.
  task automatic issue(input int d, input logic wr, input line_addr_t a, input line_t l);
    int unsigned n = 0;
    while (!exp_ready(d) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!exp_ready(d)) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout dut%0d: ready got 0 required 1", d);
    end
    req_valid[d]  = 1'b1;
    req_hwrite[d] = wr;
    req_addr[d]   = a;
    req_line[d]   = l;
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
  endtask

  task automatic wait_rsp(input int d, output int unsigned cyc);
    cyc = 0;
    while (!rsp_valid[d] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_read(input int d, input line_addr_t a, input line_t exp_line, input int unsigned exp_lat);
    int unsigned cyc;
    issue(d, 1'b0, a, '0);
    wait_rsp(d, cyc);
    chk("read_latency", d, 128'(cyc), 128'(exp_lat));
    chk("read_line", d, rsp_line[d], exp_line);
    @(posedge clk); #1;
    chk("ready_after_rsp", d, 128'(req_ready[d]), 128'(1));
  endtask

  line_t pat_dead, pat_aa, pat_a1, pat_b2, pat_99;

  initial begin
    int unsigned cyc;
    pat_dead = 128'hDEADBEEF_CAFEF00D_01234567_89AB0123;
    pat_aa   = {16{8'hAA}};
    pat_a1   = {16{8'hA1}};
    pat_b2   = {16{8'hB2}};
    pat_99   = {16{8'h99}};
    req_valid  = '0;
    req_hwrite = '0;
    rsp_ready  = '1;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = '0;
      req_hsize[d] = 3'd4;
      req_hprot[d] = 2'd3;
      req_line[d]  = '0;
    end

    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", d, 128'(req_ready[d]), 128'(0));
      chk("rst_rsp_valid", d, 128'(rsp_valid[d]), 128'(0));
      chk("rst_rsp_line",  d, rsp_line[d], 128'(0));
      chk("rst_init_done", d, 128'(init_done[d]), 128'(0));
      chk("rst_rd_count",  d, 128'(rd_count[d]), 128'(0));
      chk("rst_wr_count",  d, 128'(wr_count[d]), 128'(0));
    end
    #20 rst = 1'b1;

    @(posedge clk); #1;
    for (int c = 1; c < 16; c++) begin
      chk("init_ready_low", 0, 128'(req_ready[0]), 128'(0));
      chk("init_done_low",  0, 128'(init_done[0]), 128'(0));
      @(posedge clk); #1;
    end
    chk("init_ready_high", 0, 128'(req_ready[0]), 128'(1));
    chk("init_done_high",  0, 128'(init_done[0]), 128'(1));

    do_read(0, 28'h5, 128'(0), 4);

    issue(0, 1'b1, 28'h3, pat_dead);
    do_read(0, 28'h3, pat_dead, 4);
    chk("cnt_rd_after_wr_rd", 0, 128'(rd_count[0]), 128'(2));
    chk("cnt_wr_after_wr_rd", 0, 128'(wr_count[0]), 128'(1));

    // Stalled response: a write offered during the stall must not be taken.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 28'h3, '0);
    wait_rsp(0, cyc);
    chk("stall_latency", 0, 128'(cyc), 128'(4));
    req_valid[0]  = 1'b1;
    req_hwrite[0] = 1'b1;
    req_addr[0]   = 28'h7;
    req_line[0]   = pat_99;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", 0, 128'(rsp_valid[0]), 128'(1));
      chk("stall_line",  0, rsp_line[0], pat_dead);
      chk("stall_ready", 0, 128'(req_ready[0]), 128'(0));
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("stall_released_valid", 0, 128'(rsp_valid[0]), 128'(0));
    chk("stall_released_ready", 0, 128'(req_ready[0]), 128'(1));
    chk("stall_wr_count", 0, 128'(wr_count[0]), 128'(1));

    issue(0, 1'b1, 28'h13, pat_aa);
    do_read(0, 28'h03, pat_aa, 4);
    do_read(0, 28'hABCDE07, 128'(0), 4);

    issue(1, 1'b1, 28'h1, pat_a1);
    issue(1, 1'b1, 28'h2, pat_b2);
    do_read(1, 28'h1, pat_a1, 1);
    do_read(1, 28'h2, pat_b2, 1);
    chk("l1_rd_count", 1, 128'(rd_count[1]), 128'(2));
    chk("l1_wr_count", 1, 128'(wr_count[1]), 128'(2));

    // Reset while a read is in its latency wait.
    issue(0, 1'b0, 28'h3, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_wait_valid", 0, 128'(rsp_valid[0]), 128'(0));
    chk("rst_wait_line",  0, rsp_line[0], 128'(0));
    chk("rst_wait_rd",    0, 128'(rd_count[0]), 128'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_valid", 0, 128'(rsp_valid[0]), 128'(0));
    end
    rst = 1'b1;
    repeat (16) begin
      @(posedge clk); #1;
    end
    chk("reinit_done", 0, 128'(init_done[0]), 128'(1));
    chk("reinit_rd",   0, 128'(rd_count[0]), 128'(0));
    chk("reinit_wr",   0, 128'(wr_count[0]), 128'(0));
    do_read(0, 28'h3, 128'(0), 4);
    issue(0, 1'b1, 28'h9, pat_dead);
    do_read(0, 28'h9, pat_dead, 4);
    chk("reinit_rd_after", 0, 128'(rd_count[0]), 128'(2));
    chk("reinit_wr_after", 0, 128'(wr_count[0]), 128'(1));

    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        req_valid[d]  = ($urandom_range(0, 1) == 1);
        req_hwrite[d] = ($urandom_range(0, 1) == 1);
        req_addr[d]   = line_addr_t'($urandom);
        req_hsize[d]  = 3'($urandom);
        req_hprot[d]  = 2'($urandom);
        req_line[d]   = {$urandom, $urandom, $urandom, $urandom};
        rsp_ready[d]  = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) begin
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
